mem_req_queue: RTL and testbench
================================

Name: mem_req_queue

Overview:
In-order load/store request buffer that sits between the EX/MEM pipeline register and memory_system.
- Accepts one memory request per cycle from EX/MEM (address, store data, cntrl, Z).
- Tags each request with a 4-bit queue id, issues it to memory_system, and collects the id-tagged completions.
- Retires requests in program order; retired loads go to MEM/WB.
- Drives the pipeline stall when the buffer is full.

Parameters:
DEPTH, 16, number of entries; must equal 2^ID_W
ID_W, 4, id width; matches memory_system id_in/id_out
ADDR_W, 32, address width
DATA_W, 32, data width
CNTRL_W, 16, carried control-bundle width
Z_W, 4, carried Z width

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
enq_valid_in  in  1  EX/MEM presents a memory op this cycle
enq_rw_in  in  1  1 = store, 0 = load
enq_addr_in  in  ADDR_W  alu_out, the effective address
enq_data_in  in  DATA_W  store data (wdata)
enq_cntrl_in  in  CNTRL_W  cntrl.w bundle, carried to writeback
enq_Z_in  in  Z_W  Z, carried to writeback
stall_out  out  1  queue full; pipeline must hold EX/MEM
mem_valid_out  out  1  request valid to memory_system
mem_rw_out  out  1  r/w of issued request
mem_addr_out  out  ADDR_W  address of issued request
mem_data_out  out  DATA_W  store data of issued request
mem_id_out  out  ID_W  entry index of issued request
mem_stall_in  in  1  memory_system stall_out
mem_ready_in  in  1  memory_system ready_out
mem_id_in  in  ID_W  memory_system id_out
mem_data_in  in  DATA_W  memory_system data_out
wb_valid_out  out  1  one-cycle pulse: a load retired
wb_data_out  out  DATA_W  load data
wb_cntrl_out  out  CNTRL_W  cntrl of the retired load
wb_Z_out  out  Z_W  Z of the retired load
err_out  out  1  sticky flag: completion with an illegal id

Behaviour:
- Storage is a circular buffer. The entry index is the id.
- Entry state is one of FREE, WAIT, ISSUED, DONE.
- Pointers: tail (allocate), iss (next to issue), head (oldest). All are ID_W bits wide and wrap modulo DEPTH.
- count is ID_W+1 bits, range 0..DEPTH.
- Reset (async, rst=1):
  - all entries FREE; tail, iss, head and count = 0
  - wb_valid_out=0, wb_data_out=0, wb_cntrl_out=0, wb_Z_out=0, err_out=0
  - in-flight requests are discarded
- stall_out = (count==DEPTH), decoded from registered count.
- Enqueue:
  - Fires when enq_valid_in && !stall_out.
  - Writes entry[tail] with state WAIT, then tail++.
  - An enq while full is ignored. This holds even if a retire happens in the same cycle.
- Issue:
  - mem_valid_out = (entry[iss].state==WAIT). Combinational from state only; it does not depend on mem_stall_in.
  - mem_* outputs carry entry[iss] fields, with mem_id_out=iss.
  - The transfer fires when mem_valid_out && !mem_stall_in. The entry becomes ISSUED and iss++.
  - While mem_stall_in=1, the request is held stable.
- Latency: a request enqueued at edge k shows mem_valid_out=1 in the cycle after edge k.
- Completion:
  - On mem_ready_in=1, if entry[mem_id_in] is ISSUED it becomes DONE. Load data is captured from mem_data_in; for stores, mem_data_in is ignored.
  - If that entry is not ISSUED, nothing changes and err_out is set to 1. err_out clears only on rst.
- Retire:
  - When entry[head] is DONE, at the next edge: entry FREE, head++.
  - For a load, wb_valid_out=1 for exactly one cycle with the entry's data, cntrl and Z.
  - For a store, wb_valid_out=0.
  - Rate is at most one retire per cycle. Completions that arrive out of order wait at DONE until they are oldest.
- Simultaneous events:
  - Enqueue, issue, completion and retire may all occur in one cycle. Each acts on different state fields.
  - count_next = count + enq - retire.
  - A completion and a retire of the same entry in one cycle cannot occur: retire requires DONE at the sampling edge.
  - Issue and enqueue of the same entry in one cycle cannot occur: the WAIT state becomes visible only after the edge.
- Wrap-around: pointers wrap from DEPTH-1 to 0. The full/empty distinction comes from count, never from pointer compare.
- Store-to-load ordering is guaranteed by in-order issue. No forwarding.

Decomposition:
- Shared package mem_pkg holds:
  - entry state encoding (FREE=2'd0, WAIT=2'd1, ISSUED=2'd2, DONE=2'd3)
  - ID_W, ADDR_W, DATA_W, CNTRL_W, Z_W constants
  - the entry struct typedef
- No sub-module. The entry array and three pointers are a single block.

Test Plan:
1. Reset mid-operation: 3 loads in flight, assert rst -> all outputs 0, count 0; a late mem_ready_in with id 1 -> err_out=1, no wb pulse.
2. Single load: addr 0x40, cntrl 0x00A5, Z 3; memory returns id 0 with data 0xDEADBEEF -> mem_valid_out one cycle after enq; wb_valid_out pulse with 0xDEADBEEF, 0x00A5, 3.
3. Fill: 16 back-to-back enqueues with mem_stall_in=1 -> stall_out=1 after the 16th; a 17th enq is ignored; mem_id_out holds 0 stable.
4. Out-of-order completion: issue ids 0,1,2; complete 2, then 0, then 1 -> wb pulses in order 0,1,2; no pulse before id 0 completes.
5. Wrap-around: 40 load/store pairs with random memory latency -> ids wrap 15→0; loads return stored values; stores produce no wb pulse; err_out stays 0.
6. Full with simultaneous retire: count=16, head DONE and enq_valid_in=1 in the same cycle -> enq refused, count becomes 15, stall_out deasserts in the next cycle.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types for the in-order memory request queue: entry state encoding,
// datapath widths and the per-entry payload record.
package mem_pkg;

  localparam int ID_W    = 4;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int CNTRL_W = 16;
  localparam int Z_W     = 4;

  typedef enum logic [1:0] {
    ST_FREE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ISSUED = 2'd2,
    ST_DONE   = 2'd3
  } ent_st_e;

  // Payload only; the state lives in its own array so it alone needs reset.
  typedef struct packed {
    logic               rw;
    logic [ADDR_W-1:0]  addr;
    logic [DATA_W-1:0]  data;
    logic [CNTRL_W-1:0] cntrl;
    logic [Z_W-1:0]     z;
  } entry_t;

endpackage

// File: rtl/mem_req_queue.sv
// In-order load/store buffer between EX/MEM and memory_system: tags requests
// with their slot index, issues in order, collects tagged completions, retires in order.
module mem_req_queue
  import mem_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enq_valid_in,
  input  logic               enq_rw_in,
  input  logic [ADDR_W-1:0]  enq_addr_in,
  input  logic [DATA_W-1:0]  enq_data_in,
  input  logic [CNTRL_W-1:0] enq_cntrl_in,
  input  logic [Z_W-1:0]     enq_Z_in,
  output logic               stall_out,
  output logic               mem_valid_out,
  output logic               mem_rw_out,
  output logic [ADDR_W-1:0]  mem_addr_out,
  output logic [DATA_W-1:0]  mem_data_out,
  output logic [ID_W-1:0]    mem_id_out,
  input  logic               mem_stall_in,
  input  logic               mem_ready_in,
  input  logic [ID_W-1:0]    mem_id_in,
  input  logic [DATA_W-1:0]  mem_data_in,
  output logic               wb_valid_out,
  output logic [DATA_W-1:0]  wb_data_out,
  output logic [CNTRL_W-1:0] wb_cntrl_out,
  output logic [Z_W-1:0]     wb_Z_out,
  output logic               err_out
);

  ent_st_e         st  [DEPTH];
  entry_t          ent [DEPTH];
  logic [ID_W-1:0] tail, iss, head;
  logic [ID_W:0]   count;

  logic enq_fire, iss_fire, cpl_ok, ret;

  assign stall_out     = (count == (ID_W+1)'(DEPTH));
  assign enq_fire      = enq_valid_in && !stall_out;
  assign mem_valid_out = (st[iss] == ST_WAIT);
  assign iss_fire      = mem_valid_out && !mem_stall_in;
  assign cpl_ok        = mem_ready_in && (st[mem_id_in] == ST_ISSUED);
  assign ret           = (st[head] == ST_DONE);

  assign mem_rw_out   = ent[iss].rw;
  assign mem_addr_out = ent[iss].addr;
  assign mem_data_out = ent[iss].data;
  assign mem_id_out   = iss;

  // Enqueue, issue, completion and retire always touch distinct slots
  // (FREE / WAIT / ISSUED / DONE), so their state writes never collide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) st[i] <= ST_FREE;
      tail         <= '0;
      iss          <= '0;
      head         <= '0;
      count        <= '0;
      wb_valid_out <= 1'b0;
      wb_data_out  <= '0;
      wb_cntrl_out <= '0;
      wb_Z_out     <= '0;
      err_out      <= 1'b0;
    end else begin
      wb_valid_out <= 1'b0;
      if (enq_fire) begin
        st[tail] <= ST_WAIT;
        tail     <= tail + 1'b1;
      end
      if (iss_fire) begin
        st[iss] <= ST_ISSUED;
        iss     <= iss + 1'b1;
      end
      if (mem_ready_in) begin
        if (cpl_ok) st[mem_id_in] <= ST_DONE;
        else        err_out       <= 1'b1;
      end
      if (ret) begin
        st[head] <= ST_FREE;
        head     <= head + 1'b1;
        if (!ent[head].rw) begin
          wb_valid_out <= 1'b1;
          wb_data_out  <= ent[head].data;
          wb_cntrl_out <= ent[head].cntrl;
          wb_Z_out     <= ent[head].z;
        end
      end
      count <= count + (ID_W+1)'(enq_fire) - (ID_W+1)'(ret);
    end
  end

  // Payload needs no reset: a slot is only read once its state says it was written.
  always_ff @(posedge clk) begin
    if (enq_fire)
      ent[tail] <= '{rw: enq_rw_in, addr: enq_addr_in, data: enq_data_in,
                     cntrl: enq_cntrl_in, z: enq_Z_in};
    if (cpl_ok && !ent[mem_id_in].rw)
      ent[mem_id_in].data <= mem_data_in;
  end

endmodule

// File: tb/tb_mem_req_queue.sv
// Directed bench for mem_req_queue: a vector table for single-entry flows plus
// hand-written sequences for reset, fill, reordering, wrap and full+retire.
module tb_mem_req_queue;
  import mem_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               enq_valid_in, enq_rw_in;
  logic [ADDR_W-1:0]  enq_addr_in;
  logic [DATA_W-1:0]  enq_data_in;
  logic [CNTRL_W-1:0] enq_cntrl_in;
  logic [Z_W-1:0]     enq_Z_in;
  logic               stall_out, mem_valid_out, mem_rw_out;
  logic [ADDR_W-1:0]  mem_addr_out;
  logic [DATA_W-1:0]  mem_data_out;
  logic [ID_W-1:0]    mem_id_out;
  logic               mem_stall_in, mem_ready_in;
  logic [ID_W-1:0]    mem_id_in;
  logic [DATA_W-1:0]  mem_data_in;
  logic               wb_valid_out;
  logic [DATA_W-1:0]  wb_data_out;
  logic [CNTRL_W-1:0] wb_cntrl_out;
  logic [Z_W-1:0]     wb_Z_out;
  logic               err_out;

  mem_req_queue #(.DEPTH(16)) dut (
    .clk(clk), .rst(rst),
    .enq_valid_in(enq_valid_in), .enq_rw_in(enq_rw_in), .enq_addr_in(enq_addr_in),
    .enq_data_in(enq_data_in), .enq_cntrl_in(enq_cntrl_in), .enq_Z_in(enq_Z_in),
    .stall_out(stall_out),
    .mem_valid_out(mem_valid_out), .mem_rw_out(mem_rw_out), .mem_addr_out(mem_addr_out),
    .mem_data_out(mem_data_out), .mem_id_out(mem_id_out),
    .mem_stall_in(mem_stall_in), .mem_ready_in(mem_ready_in),
    .mem_id_in(mem_id_in), .mem_data_in(mem_data_in),
    .wb_valid_out(wb_valid_out), .wb_data_out(wb_data_out),
    .wb_cntrl_out(wb_cntrl_out), .wb_Z_out(wb_Z_out), .err_out(err_out)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Retired-load log: {data, cntrl, Z}, sampled 1 time unit after each edge.
  logic [51:0] wb_q[$];
  always begin
    @(posedge clk); #1;
    if (wb_valid_out) wb_q.push_back({wb_data_out, wb_cntrl_out, wb_Z_out});
  end

  task automatic idle_inputs();
    enq_valid_in = 0; enq_rw_in = 0; enq_addr_in = '0; enq_data_in = '0;
    enq_cntrl_in = '0; enq_Z_in = '0;
    mem_stall_in = 0; mem_ready_in = 0; mem_id_in = '0; mem_data_in = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic enq(input logic rw, input logic [31:0] a, input logic [31:0] d,
                     input logic [15:0] c, input logic [3:0] z);
    enq_valid_in = 1; enq_rw_in = rw; enq_addr_in = a; enq_data_in = d;
    enq_cntrl_in = c; enq_Z_in = z;
  endtask

  typedef struct {
    logic ev, rw; logic [31:0] addr, wdata; logic [15:0] cntrl; logic [3:0] z;
    logic ms, mr; logic [3:0] mid; logic [31:0] mdata;
    logic x_stall, x_mval; logic [3:0] x_mid; logic [31:0] x_addr, x_mdata;
    logic x_wbv; logic [31:0] x_wbd; logic [15:0] x_wbc; logic [3:0] x_wbz; logic x_err;
  } vec_t;

  vec_t vt [10];

  initial begin
    rst = 1'b1;
    idle_inputs();

    // ---------------- Test 1: reset mid-operation ----------------
    do_reset();
    for (int i = 0; i < 3; i++) begin
      enq(0, 32'h200 + 32'(i*4), 0, 16'(i), 4'(i));
      step(); @(negedge clk);
    end
    enq_valid_in = 0;
    step(); @(negedge clk);
    step(); @(negedge clk);
    rst = 1'b1; #1;
    chk("t1_rst_stall", stall_out, 0);
    chk("t1_rst_mval", mem_valid_out, 0);
    chk("t1_rst_wbv", wb_valid_out, 0);
    chk("t1_rst_wbdata", {wb_data_out, wb_cntrl_out, wb_Z_out}, 0);
    chk("t1_rst_err", err_out, 0);
    chk("t1_rst_count", dut.count, 0);
    @(negedge clk); rst = 1'b0;
    wb_q.delete();
    mem_ready_in = 1; mem_id_in = 4'd1; mem_data_in = 32'h0000AAAA;
    step(); @(negedge clk);
    chk("t1_late_err", err_out, 1);
    mem_ready_in = 0;
    step(); @(negedge clk);
    chk("t1_no_wb", wb_q.size(), 0);

    // ---------------- Test 2: vector table, single load + store ----------------
    do_reset();
    vt[0] = '{1,0,32'h40,0,16'h00A5,4'd3, 1,0,0,0,  0,1,0,32'h40,0,        0,0,0,0,0};
    vt[1] = '{0,0,0,0,0,0,                1,0,0,0,  0,1,0,32'h40,0,        0,0,0,0,0};
    vt[2] = '{0,0,0,0,0,0,                0,0,0,0,  0,0,1,0,0,             0,0,0,0,0};
    vt[3] = '{0,0,0,0,0,0,  0,1,4'd0,32'hDEADBEEF,  0,0,1,0,0,             0,0,0,0,0};
    vt[4] = '{0,0,0,0,0,0,                0,0,0,0,  0,0,1,0,0,  1,32'hDEADBEEF,16'h00A5,4'd3,0};
    vt[5] = '{1,1,32'h80,32'h12345678,16'h0001,4'd1, 0,0,0,0, 0,1,1,32'h80,32'h12345678, 0,0,0,0,0};
    vt[6] = '{0,0,0,0,0,0,                0,0,0,0,  0,0,2,0,0,             0,0,0,0,0};
    vt[7] = '{0,0,0,0,0,0,  0,1,4'd1,32'hFFFFFFFF,  0,0,2,0,0,             0,0,0,0,0};
    vt[8] = '{0,0,0,0,0,0,                0,0,0,0,  0,0,2,0,0,             0,0,0,0,0};
    vt[9] = '{0,0,0,0,0,0,  0,1,4'd5,32'h0,         0,0,2,0,0,             0,0,0,0,1};
    for (int i = 0; i < 10; i++) begin
      enq_valid_in = vt[i].ev; enq_rw_in = vt[i].rw; enq_addr_in = vt[i].addr;
      enq_data_in = vt[i].wdata; enq_cntrl_in = vt[i].cntrl; enq_Z_in = vt[i].z;
      mem_stall_in = vt[i].ms; mem_ready_in = vt[i].mr; mem_id_in = vt[i].mid;
      mem_data_in = vt[i].mdata;
      step();
      chk($sformatf("v%0d_stall", i), stall_out, vt[i].x_stall);
      chk($sformatf("v%0d_mval", i), mem_valid_out, vt[i].x_mval);
      chk($sformatf("v%0d_mid", i), mem_id_out, vt[i].x_mid);
      chk($sformatf("v%0d_wbv", i), wb_valid_out, vt[i].x_wbv);
      chk($sformatf("v%0d_err", i), err_out, vt[i].x_err);
      if (vt[i].x_mval) begin
        chk($sformatf("v%0d_maddr", i), mem_addr_out, vt[i].x_addr);
        chk($sformatf("v%0d_mdata", i), mem_data_out, vt[i].x_mdata);
      end
      if (vt[i].x_wbv)
        chk($sformatf("v%0d_wb", i), {wb_data_out, wb_cntrl_out, wb_Z_out},
            {vt[i].x_wbd, vt[i].x_wbc, vt[i].x_wbz});
      @(negedge clk);
    end

    // ---------------- Test 3: fill to 16 with memory stalled ----------------
    do_reset();
    mem_stall_in = 1;
    for (int i = 0; i < 16; i++) begin
      enq(0, 32'h100 + 32'(i*4), 0, 16'(i), 4'(i));
      step();
      chk($sformatf("t3_stall_%0d", i), stall_out, (i == 15));
      chk($sformatf("t3_mid_%0d", i), {mem_valid_out, mem_id_out}, {1'b1, 4'd0});
      @(negedge clk);
    end
    enq(0, 32'hBAD, 0, 16'hFFFF, 4'hF);
    step();
    chk("t3_17th_stall", stall_out, 1);
    chk("t3_17th_count", dut.count, 16);
    chk("t3_17th_tail", dut.tail, 0);
    chk("t3_hold_addr", mem_addr_out, 32'h100);
    @(negedge clk);

    // ---------------- Test 6: full + retire in same cycle ----------------
    enq_valid_in = 0; mem_stall_in = 0;
    step(); @(negedge clk);
    mem_stall_in = 1; mem_ready_in = 1; mem_id_in = 0; mem_data_in = 32'hCAFEF00D;
    step();
    chk("t6_full_before", stall_out, 1);
    @(negedge clk);
    mem_ready_in = 0;
    enq(0, 32'h777, 0, 16'h7777, 4'h7);
    step();
    chk("t6_count", dut.count, 15);
    chk("t6_stall_off", stall_out, 0);
    chk("t6_tail", dut.tail, 0);
    chk("t6_wb", {wb_valid_out, wb_data_out, wb_cntrl_out, wb_Z_out},
        {1'b1, 32'hCAFEF00D, 16'h0000, 4'h0});
    @(negedge clk);

    // ---------------- Test 4: out-of-order completion ----------------
    do_reset();
    for (int i = 0; i < 3; i++) begin
      enq(0, 32'h300 + 32'(i*4), 0, 16'h10 + 16'(i), 4'(i));
      step(); @(negedge clk);
    end
    enq_valid_in = 0;
    for (int i = 0; i < 3; i++) begin step(); @(negedge clk); end
    wb_q.delete();
    mem_ready_in = 1; mem_id_in = 2; mem_data_in = 32'hD2D2D2D2;
    step(); @(negedge clk);
    mem_ready_in = 0;
    step(); @(negedge clk);
    step(); @(negedge clk);
    chk("t4_no_early_wb", wb_q.size(), 0);
    mem_ready_in = 1; mem_id_in = 0; mem_data_in = 32'hD0D0D0D0;
    step(); @(negedge clk);
    mem_id_in = 1; mem_data_in = 32'hD1D1D1D1;
    step(); @(negedge clk);
    mem_ready_in = 0;
    for (int i = 0; i < 3; i++) begin step(); @(negedge clk); end
    chk("t4_wb_count", wb_q.size(), 3);
    if (wb_q.size() == 3) begin
      chk("t4_wb0", wb_q[0], {32'hD0D0D0D0, 16'h10, 4'd0});
      chk("t4_wb1", wb_q[1], {32'hD1D1D1D1, 16'h11, 4'd1});
      chk("t4_wb2", wb_q[2], {32'hD2D2D2D2, 16'h12, 4'd2});
    end
    chk("t4_err", err_out, 0);

    // ---------------- Test 5: wrap with random memory latency ----------------
    begin
      typedef struct { logic [3:0] id; logic [31:0] d; int dly; } pend_t;
      pend_t       pend[$];
      logic [31:0] mem_m [logic [31:0]];
      logic [31:0] sd [40];
      logic [51:0] exp_q[$];
      int          idx = 0;
      bit          saw15 = 0, wrapped = 0, done = 0;
      do_reset();
      wb_q.delete();
      for (int p = 0; p < 40; p++) sd[p] = $urandom;
      for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
        idle_inputs();
        if (idx < 80 && !stall_out) begin
          int p = idx / 2;
          if (idx % 2 == 0) enq(1, 32'h1000 + 32'(p*4), sd[p], 16'h8000 | 16'(p), 4'(p));
          else begin
            enq(0, 32'h1000 + 32'(p*4), 0, 16'(p), 4'(p));
            exp_q.push_back({sd[p], 16'(p), 4'(p)});
          end
          idx++;
        end
        mem_stall_in = ($urandom_range(3) == 0);
        for (int k = 0; k < pend.size(); k++) begin
          if (pend[k].dly <= 0) begin
            mem_ready_in = 1; mem_id_in = pend[k].id; mem_data_in = pend[k].d;
            pend.delete(k);
            break;
          end
        end
        if (mem_valid_out && !mem_stall_in) begin
          pend_t n;
          n.id = mem_id_out; n.dly = $urandom_range(6, 1);
          if (mem_rw_out) begin mem_m[mem_addr_out] = mem_data_out; n.d = $urandom; end
          else n.d = mem_m.exists(mem_addr_out) ? mem_m[mem_addr_out] : 32'h0;
          pend.push_back(n);
          if (mem_id_out == 4'd15) saw15 = 1;
          if (saw15 && mem_id_out == 4'd0) wrapped = 1;
        end
        step(); @(negedge clk);
        foreach (pend[k]) pend[k].dly--;
        if (idx == 80 && pend.size() == 0 && dut.count == 0) done = 1;
      end
      idle_inputs();
      step(); @(negedge clk);
      step(); @(negedge clk);
      chk("t5_done", done, 1);
      chk("t5_wrap", wrapped, 1);
      chk("t5_err", err_out, 0);
      chk("t5_wb_count", wb_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < wb_q.size(); i++)
        chk($sformatf("t5_wb%0d", i), wb_q[i], exp_q[i]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
